// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT/IFFT input streaming path.
// Lane-state encoding, fixed stream widths and beat-counter sizing.
package fft_stream_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;
    localparam int unsigned BEAT_WIDTH   = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } lane_state_t;

    function automatic int unsigned beat_cnt_width(input int unsigned points);
        return $clog2(points / 2);
    endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Per-frame beat counter with terminal flag, resync clear and a wrapping
// completed-frame counter.
module fft_frame_counter #(
    parameter int unsigned FFT_POINTS = 1024,
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_load,
    input  logic                  resync,
    output logic                  terminal,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);
    import fft_stream_pkg::*;

    localparam int unsigned CW = beat_cnt_width(FFT_POINTS);
    localparam logic [CW-1:0] TERM = CW'(FFT_POINTS / 2 - 1);

    logic [CW-1:0] beat_cnt;
    logic          frame_end;

    assign terminal  = (beat_cnt == TERM);
    // A frame closes either by count or by an upstream marker forcing resync.
    assign frame_end = beat_load && (terminal || resync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_end) begin
                beat_cnt  <= '0;
                frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
            end else if (resync) begin
                beat_cnt <= '0;
            end else if (beat_load) begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fft_sample_packer.sv
// Packs pairs of 32-bit complex samples into 64-bit beats, marks frame ends
// by count and resynchronises on upstream frame-marker mismatches.
module fft_sample_packer #(
    parameter int unsigned SAMPLE_WIDTH = fft_stream_pkg::SAMPLE_WIDTH,
    parameter int unsigned BEAT_WIDTH   = fft_stream_pkg::BEAT_WIDTH,
    parameter int unsigned FFT_POINTS   = 1024,
    parameter int unsigned FCNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [BEAT_WIDTH-1:0]   m_data,
    output logic                    m_last,
    output logic                    frame_err,
    output logic [FCNT_WIDTH-1:0]   frame_cnt
);
    import fft_stream_pkg::*;

    lane_state_t             state, state_nxt;
    logic [SAMPLE_WIDTH-1:0] lane0;
    logic                    out_free;
    logic                    accept;
    logic                    load_beat;
    logic                    terminal;
    logic [BEAT_WIDTH-1:0]   beat_nxt;
    logic                    last_nxt;
    logic                    err_nxt;

    assign out_free = !m_valid || m_ready;
    // An early marker in EMPTY emits a beat at once, so it also needs out_free.
    assign s_ready   = rst_n && (((state == EMPTY) && !s_last) || out_free);
    assign accept    = s_valid && s_ready;
    assign load_beat = accept && ((state == HALF) || s_last);

    fft_frame_counter #(
        .FFT_POINTS (FFT_POINTS),
        .FCNT_WIDTH (FCNT_WIDTH)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_load (load_beat),
        .resync    (accept && s_last),
        .terminal  (terminal),
        .frame_cnt (frame_cnt)
    );

    always_comb begin
        state_nxt = state;
        beat_nxt  = {{SAMPLE_WIDTH{1'b0}}, s_data};
        last_nxt  = terminal || s_last;
        err_nxt   = 1'b0;
        if (state == HALF) begin
            beat_nxt = {s_data, lane0};
        end
        if (accept) begin
            // Mismatch whenever the marker disagrees with "final sample by count".
            err_nxt = (s_last != ((state == HALF) && terminal));
            if (state == HALF) begin
                state_nxt = EMPTY;
            end else if (!s_last) begin
                state_nxt = HALF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            lane0     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= err_nxt;
            if (accept && (state == EMPTY) && !s_last) begin
                lane0 <= s_data;
            end
            if (load_beat) begin
                m_valid <= 1'b1;
                m_data  <= beat_nxt;
                m_last  <= last_nxt;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_sample_packer.sv
// Self-checking bench for fft_sample_packer with 8-point frames and a 4-bit
// frame counter; expected beats are queued on acceptance and checked on drain.
module tb_fft_sample_packer;

    localparam int unsigned PTS = 8;
    localparam int unsigned FCW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [31:0]    s_data = '0;
    logic           s_last = 1'b0;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic [63:0]    m_data;
    logic           m_last;
    logic           frame_err;
    logic [FCW-1:0] frame_cnt;

    always #5 clk = ~clk;

    fft_sample_packer #(
        .FFT_POINTS (PTS),
        .FCNT_WIDTH (FCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        emit;
        logic [63:0] beat;
        logic        bl;
        logic        err;
    } vec_t;

    beat_t       sbq[$];
    vec_t        tbl[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned stall_left = 0;
    logic        cur_emit = 1'b0, cur_bl = 1'b0, cur_err = 1'b0;
    logic [63:0] cur_beat = '0;
    logic        err_exp = 1'b0, hold_chk = 1'b0, prev_last = 1'b0, last_acc = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] d, input logic l, input logic emit,
                                input logic [63:0] beat, input logic bl, input logic err);
        vec_t v;
        v.d = d; v.l = l; v.emit = emit; v.beat = beat; v.bl = bl; v.err = err;
        tbl.push_back(v);
    endfunction

    // One clock: drive m_ready, check pre-edge outputs, record acceptance, advance.
    task automatic step();
        beat_t e;
        beat_t nb;
        logic  acc;
        logic  err_n;
        m_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        #1;
        if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_beat: got %h expected no beat", m_data);
            end else begin
                e = sbq.pop_front();
                chk("beat_data", m_data, e.data);
                chk("beat_last", {63'd0, m_last}, {63'd0, e.last});
            end
        end
        if (hold_chk) begin
            chk("hold_valid", {63'd0, m_valid}, 64'd1);
            chk("hold_data", m_data, prev_data);
            chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
        end
        hold_chk  = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
        chk("frame_err", {63'd0, frame_err}, {63'd0, err_exp});
        acc   = s_valid && s_ready;
        err_n = 1'b0;
        if (acc) begin
            if (cur_emit) begin
                nb.data = cur_beat;
                nb.last = cur_bl;
                sbq.push_back(nb);
            end
            err_n = cur_err;
        end
        last_acc = acc;
        @(posedge clk);
        err_exp = err_n;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic emit,
                        input logic [63:0] beat, input logic bl, input logic err,
                        output int unsigned waits);
        logic done;
        done = 1'b0;
        waits = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        cur_emit = emit; cur_beat = beat; cur_bl = bl; cur_err = err;
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_acc) begin
                done = 1'b1;
                break;
            end
            waits++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept of %h", d);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic flush();
        logic done;
        done = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sbq.size() == 0 && !m_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        logic [31:0] d;

        // T1: normal frame 1..8 with marker on sample 8
        for (int unsigned k = 1; k <= 8; k++) begin
            d = 32'(k);
            if (k % 2 == 0)
                add(d, k == 8, 1'b1, {d, 32'(k - 1)}, k == 8, 1'b0);
            else
                add(d, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        // T3: early marker on odd sample, then T4: eight samples with no marker
        add(32'hA1, 0, 0, '0, 0, 0);
        add(32'hA2, 0, 1, 64'h000000A2_000000A1, 0, 0);
        add(32'hA3, 1, 1, 64'h00000000_000000A3, 1, 1);
        add(32'hB1, 0, 0, '0, 0, 0);
        add(32'hB2, 0, 1, 64'h000000B2_000000B1, 0, 0);
        add(32'hB3, 0, 0, '0, 0, 0);
        add(32'hB4, 0, 1, 64'h000000B4_000000B3, 0, 0);
        add(32'hB5, 0, 0, '0, 0, 0);
        add(32'hB6, 0, 1, 64'h000000B6_000000B5, 0, 0);
        add(32'hB7, 0, 0, '0, 0, 0);
        add(32'hB8, 0, 1, 64'h000000B8_000000B7, 1, 1);

        repeat (3) @(negedge clk);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", {63'd0, m_last}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].l, tbl[i].emit, tbl[i].beat, tbl[i].bl, tbl[i].err, w);
            chk("table_no_wait", 64'(w), 64'd0);
            if (i == 7) begin
                flush();
                chk("frame_cnt_t1", 64'(frame_cnt), 64'd1);
            end
        end
        flush();
        chk("frame_cnt_t4", 64'(frame_cnt), 64'd3);

        // Backpressure: first beat held for 5 cycles
        send(32'h11, 0, 0, '0, 0, 0, w);
        send(32'h12, 0, 1, 64'h00000012_00000011, 0, 0, w);
        stall_left = 5;
        send(32'h13, 0, 0, '0, 0, 0, w);
        chk("stall_empty_wait", 64'(w), 64'd0);
        send(32'h14, 0, 1, 64'h00000014_00000013, 0, 0, w);
        chk("stall_half_wait", 64'(w), 64'd4);
        send(32'h15, 0, 0, '0, 0, 0, w);
        send(32'h16, 0, 1, 64'h00000016_00000015, 0, 0, w);
        send(32'h17, 0, 0, '0, 0, 0, w);
        send(32'h18, 1, 1, 64'h00000018_00000017, 1, 0, w);
        flush();
        chk("frame_cnt_stall", 64'(frame_cnt), 64'd4);

        // Early marker in EMPTY must wait for the output register to free up
        send(32'hC1, 0, 0, '0, 0, 0, w);
        stall_left = 3;
        send(32'hC2, 0, 1, 64'h000000C2_000000C1, 0, 0, w);
        chk("odd_half_wait", 64'(w), 64'd0);
        send(32'hC3, 1, 1, 64'h00000000_000000C3, 1, 1, w);
        chk("odd_last_gated_wait", 64'(w), 64'd2);
        flush();
        chk("frame_cnt_odd", 64'(frame_cnt), 64'd5);

        // Asynchronous reset mid-frame with a held beat and a half-packed sample
        send(32'hD1, 0, 0, '0, 0, 0, w);
        send(32'hD2, 0, 1, 64'h000000D2_000000D1, 0, 0, w);
        stall_left = 10;
        send(32'hD3, 0, 0, '0, 0, 0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("async_m_valid", {63'd0, m_valid}, 64'd0);
        chk("async_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("async_s_ready", {63'd0, s_ready}, 64'd0);
        chk("discarded_beats", 64'(sbq.size()), 64'd1);
        sbq.delete();
        stall_left = 0; m_ready = 1'b1; hold_chk = 1'b0; err_exp = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int unsigned k = 0; k < 8; k++) begin
            d = 32'hE0 + 32'(k);
            send(d, k == 7, k % 2 == 1, {d, d - 32'd1}, k == 7, 1'b0, w);
        end
        flush();
        chk("frame_cnt_post_rst", 64'(frame_cnt), 64'd1);

        // Frame counter wrap: 16 more frames brings 17 total, 4-bit counter reads 1
        for (int unsigned f = 0; f < 16; f++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                d = {16'(f), 16'(k)};
                send(d, k == 7, k % 2 == 1, {d, d - 32'd1}, k == 7, 1'b0, w);
            end
            if (f == 14) begin
                flush();
                chk("frame_cnt_wrap0", 64'(frame_cnt), 64'd0);
            end
        end
        flush();
        chk("frame_cnt_wrap1", 64'(frame_cnt), 64'd1);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
